// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer: steps each instruction through FETCH/DECODE/EXEC/MEM/WB
// and decodes per-phase write enables from the current state and decoder fields.
module cpu_sequencer #(
   parameter int unsigned MEM_WAIT_MAX = 15
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        run_in,
   input  logic        step_in,
   input  logic [1:0]  dec_op_in,
   input  logic        dec_load_in,
   input  logic        dec_store_in,
   input  logic        dec_wr_in,
   input  logic        dec_flags_in,
   input  logic        dec_jump_in,
   input  logic        mem_ready_in,
   output logic        ir_we_out,
   output logic        pc_en_out,
   output logic        pc_sel_out,
   output logic        flags_we_out,
   output logic        reg_we_out,
   output logic        mem_req_out,
   output logic        mem_we_out,
   output logic        busy_out,
   output logic        timeout_err_out,
   output logic [2:0]  state_out,
   output logic [15:0] instr_count_out
);

   localparam int unsigned CNT_W  = 16;
   localparam int unsigned WAIT_W = 8;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_ERR    = 3'd6
   } state_t;

   localparam logic [1:0] OP_LDST  = 2'd1;
   localparam logic [1:0] OP_BRANCH = 2'd2;
   localparam logic [1:0] OP_UNDEF = 2'd3;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              step_q;
   logic              step_rise;
   logic              retire;

   // A load is implied by op=1 without store; the load flag carries no extra control.
   logic unused_load;
   assign unused_load = dec_load_in;

   assign step_rise = step_in & ~step_q;

   // State, counters and step edge detector
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         wait_q  <= '0;
         step_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wait_q  <= wait_d;
         step_q  <= step_in;
      end
   end

   // Next state and per-phase enables
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      wait_d       = wait_q;
      retire       = 1'b0;
      ir_we_out    = 1'b0;
      pc_en_out    = 1'b0;
      pc_sel_out   = 1'b0;
      flags_we_out = 1'b0;
      reg_we_out   = 1'b0;
      mem_req_out  = 1'b0;
      mem_we_out   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (run_in || step_rise) state_d = S_FETCH;
         end
         S_FETCH: begin
            ir_we_out = 1'b1;
            state_d   = S_DECODE;
         end
         S_DECODE: begin
            state_d = S_EXEC;
         end
         S_EXEC: begin
            flags_we_out = dec_flags_in & (dec_op_in != OP_UNDEF);
            if (dec_op_in == OP_LDST) begin
               state_d = S_MEM;
               wait_d  = '0;
            end else if (dec_op_in == OP_BRANCH) begin
               pc_en_out  = 1'b1;
               pc_sel_out = dec_jump_in;
               reg_we_out = dec_wr_in;
               retire     = 1'b1;
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM: begin
            mem_req_out = 1'b1;
            mem_we_out  = dec_store_in;
            if (mem_ready_in) begin
               state_d = S_WB;
            end else if (wait_q == WAIT_W'(MEM_WAIT_MAX - 1)) begin
               state_d = S_ERR;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         S_WB: begin
            pc_en_out  = 1'b1;
            reg_we_out = dec_wr_in & ~dec_store_in & (dec_op_in != OP_UNDEF);
            retire     = 1'b1;
         end
         S_ERR: begin
            state_d = S_ERR;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Retirement always finishes the instruction before honouring run_in
      if (retire) begin
         cnt_d   = cnt_q + CNT_W'(1);
         state_d = run_in ? S_FETCH : S_IDLE;
      end
   end

   assign busy_out        = (state_q != S_IDLE) && (state_q != S_ERR);
   assign timeout_err_out = (state_q == S_ERR);
   assign state_out       = state_q;
   assign instr_count_out = cnt_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: stimulus queues per-cycle expected outputs,
// a negedge monitor pops and compares them.
module tb_cpu_sequencer;

   logic        clk_in = 1'b0;
   logic        rst_in, run_in, step_in;
   logic [1:0]  dec_op_in;
   logic        dec_load_in, dec_store_in, dec_wr_in, dec_flags_in, dec_jump_in;
   logic        mem_ready_in;
   logic        ir_we_out, pc_en_out, pc_sel_out, flags_we_out, reg_we_out;
   logic        mem_req_out, mem_we_out, busy_out, timeout_err_out;
   logic [2:0]  state_out;
   logic [15:0] instr_count_out;

   typedef struct packed {
      logic [2:0]  st;
      logic [6:0]  en;   // {ir, pc_en, pc_sel, flags, reg, mem_req, mem_we}
      logic        busy;
      logic        terr;
      logic [15:0] cnt;
   } exp_t;

   typedef struct {
      exp_t  e;
      string tag;
   } item_t;

   localparam logic [6:0] E_IR  = 7'b1000000;
   localparam logic [6:0] E_PC  = 7'b0100000;
   localparam logic [6:0] E_SEL = 7'b0010000;
   localparam logic [6:0] E_FL  = 7'b0001000;
   localparam logic [6:0] E_RW  = 7'b0000100;
   localparam logic [6:0] E_MRQ = 7'b0000010;
   localparam logic [6:0] E_MWE = 7'b0000001;
   localparam logic [6:0] E_0   = 7'b0000000;

   item_t q[$];
   int    n_checks = 0;
   int    n_errors = 0;

   cpu_sequencer #(.MEM_WAIT_MAX(15)) dut (
      .clk_in          (clk_in),
      .rst_in          (rst_in),
      .run_in          (run_in),
      .step_in         (step_in),
      .dec_op_in       (dec_op_in),
      .dec_load_in     (dec_load_in),
      .dec_store_in    (dec_store_in),
      .dec_wr_in       (dec_wr_in),
      .dec_flags_in    (dec_flags_in),
      .dec_jump_in     (dec_jump_in),
      .mem_ready_in    (mem_ready_in),
      .ir_we_out       (ir_we_out),
      .pc_en_out       (pc_en_out),
      .pc_sel_out      (pc_sel_out),
      .flags_we_out    (flags_we_out),
      .reg_we_out      (reg_we_out),
      .mem_req_out     (mem_req_out),
      .mem_we_out      (mem_we_out),
      .busy_out        (busy_out),
      .timeout_err_out (timeout_err_out),
      .state_out       (state_out),
      .instr_count_out (instr_count_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic nx();
      @(posedge clk_in);
      #1;
   endtask

   // Queue the expected outputs of the current cycle
   task automatic ex(input string tag, input logic [2:0] st, input logic [6:0] en,
                     input logic [15:0] cnt);
      item_t it;
      it.e.st   = st;
      it.e.en   = en;
      it.e.busy = (st != 3'd0) && (st != 3'd6);
      it.e.terr = (st == 3'd6);
      it.e.cnt  = cnt;
      it.tag    = tag;
      q.push_back(it);
   endtask

   // Monitor: every cycle with a queued expectation is compared at negedge
   initial begin
      item_t it;
      exp_t  act;
      forever begin
         @(negedge clk_in);
         if (q.size() > 0) begin
            it  = q.pop_front();
            act = {state_out,
                   {ir_we_out, pc_en_out, pc_sel_out, flags_we_out, reg_we_out,
                    mem_req_out, mem_we_out},
                   busy_out, timeout_err_out, instr_count_out};
            n_checks++;
            if (act !== it.e) begin
               n_errors++;
               $display("FAIL %s: got st=%0d en=%b busy=%b terr=%b cnt=%0d, want st=%0d en=%b busy=%b terr=%b cnt=%0d",
                        it.tag, act.st, act.en, act.busy, act.terr, act.cnt,
                        it.e.st, it.e.en, it.e.busy, it.e.terr, it.e.cnt);
            end
         end
      end
   end

   initial begin
      rst_in = 1'b1; run_in = 1'b0; step_in = 1'b0;
      dec_op_in = 2'd0; dec_load_in = 1'b0; dec_store_in = 1'b0;
      dec_wr_in = 1'b0; dec_flags_in = 1'b0; dec_jump_in = 1'b0;
      mem_ready_in = 1'b0;
      repeat (2) @(posedge clk_in);

      // Reset state, then reset while a memory request is pending
      nx(); rst_in = 1'b0; ex("reset_idle", 3'd0, E_0, 16'd0);
      nx(); run_in = 1'b1; dec_op_in = 2'd1; dec_load_in = 1'b1; dec_wr_in = 1'b1;
      ex("r_idle", 3'd0, E_0, 16'd0);
      nx(); ex("r_fetch", 3'd1, E_IR, 16'd0);
      nx(); ex("r_decode", 3'd2, E_0, 16'd0);
      nx(); ex("r_exec", 3'd3, E_0, 16'd0);
      nx(); ex("r_mem0", 3'd4, E_MRQ, 16'd0);
      nx(); rst_in = 1'b1; ex("r_mem1", 3'd4, E_MRQ, 16'd0);
      nx(); rst_in = 1'b0; run_in = 1'b0; ex("r_after_rst", 3'd0, E_0, 16'd0);

      // Data-processing, free-running, two instructions
      nx(); run_in = 1'b1; dec_op_in = 2'd0; dec_load_in = 1'b0; dec_wr_in = 1'b1;
      dec_flags_in = 1'b1; ex("dp_idle", 3'd0, E_0, 16'd0);
      for (int i = 0; i < 2; i++) begin
         nx(); ex("dp_fetch", 3'd1, E_IR, 16'(i));
         nx(); ex("dp_decode", 3'd2, E_0, 16'(i));
         nx(); ex("dp_exec", 3'd3, E_FL, 16'(i));
         nx(); if (i == 1) run_in = 1'b0;
         ex("dp_wb", 3'd5, E_PC | E_RW, 16'(i));
      end

      // Load with three wait cycles
      nx(); run_in = 1'b1; dec_op_in = 2'd1; dec_load_in = 1'b1; dec_flags_in = 1'b0;
      mem_ready_in = 1'b0; ex("ld_idle", 3'd0, E_0, 16'd2);
      nx(); ex("ld_fetch", 3'd1, E_IR, 16'd2);
      nx(); ex("ld_decode", 3'd2, E_0, 16'd2);
      nx(); ex("ld_exec", 3'd3, E_0, 16'd2);
      for (int i = 0; i < 3; i++) begin
         nx(); ex("ld_mem_wait", 3'd4, E_MRQ, 16'd2);
      end
      nx(); mem_ready_in = 1'b1; run_in = 1'b0; ex("ld_mem_rdy", 3'd4, E_MRQ, 16'd2);
      nx(); mem_ready_in = 1'b0; ex("ld_wb", 3'd5, E_PC | E_RW, 16'd2);

      // Taken branch with write, then untaken branch with flags
      nx(); run_in = 1'b1; dec_op_in = 2'd2; dec_load_in = 1'b0; dec_jump_in = 1'b1;
      dec_wr_in = 1'b1; ex("br_idle", 3'd0, E_0, 16'd3);
      nx(); ex("br_fetch", 3'd1, E_IR, 16'd3);
      nx(); ex("br_decode", 3'd2, E_0, 16'd3);
      nx(); ex("br_exec_taken", 3'd3, E_PC | E_SEL | E_RW, 16'd3);
      nx(); dec_jump_in = 1'b0; dec_wr_in = 1'b0; dec_flags_in = 1'b1; run_in = 1'b0;
      ex("br_refetch", 3'd1, E_IR, 16'd4);
      nx(); ex("br2_decode", 3'd2, E_0, 16'd4);
      nx(); ex("br2_exec", 3'd3, E_PC | E_FL, 16'd4);

      // Undefined op: flags and register write suppressed
      nx(); run_in = 1'b1; dec_op_in = 2'd3; dec_wr_in = 1'b1; dec_flags_in = 1'b1;
      ex("u_idle", 3'd0, E_0, 16'd5);
      nx(); ex("u_fetch", 3'd1, E_IR, 16'd5);
      nx(); ex("u_decode", 3'd2, E_0, 16'd5);
      nx(); ex("u_exec", 3'd3, E_0, 16'd5);
      nx(); run_in = 1'b0; ex("u_wb", 3'd5, E_PC, 16'd5);

      // Single step; extra step pulse while busy is ignored
      nx(); dec_op_in = 2'd0; dec_flags_in = 1'b0; step_in = 1'b1;
      ex("s_idle", 3'd0, E_0, 16'd6);
      nx(); ex("s_fetch", 3'd1, E_IR, 16'd6);
      nx(); step_in = 1'b0; ex("s_decode", 3'd2, E_0, 16'd6);
      nx(); step_in = 1'b1; ex("s_exec", 3'd3, E_0, 16'd6);
      nx(); step_in = 1'b0; ex("s_wb", 3'd5, E_PC | E_RW, 16'd6);
      nx(); ex("s_idle_after", 3'd0, E_0, 16'd7);

      // Store with memory never ready -> timeout error
      nx(); run_in = 1'b1; dec_op_in = 2'd1; dec_store_in = 1'b1; dec_wr_in = 1'b0;
      mem_ready_in = 1'b0; ex("s_idle_hold", 3'd0, E_0, 16'd7);
      nx(); ex("to_fetch", 3'd1, E_IR, 16'd7);
      nx(); ex("to_decode", 3'd2, E_0, 16'd7);
      nx(); ex("to_exec", 3'd3, E_0, 16'd7);
      for (int i = 0; i < 15; i++) begin
         nx(); ex("to_mem", 3'd4, E_MRQ | E_MWE, 16'd7);
      end
      nx(); ex("to_err", 3'd6, E_0, 16'd7);
      nx(); run_in = 1'b0; ex("to_err_run0", 3'd6, E_0, 16'd7);
      nx(); run_in = 1'b1; ex("to_err_run1", 3'd6, E_0, 16'd7);
      nx(); rst_in = 1'b1; ex("to_err_rst", 3'd6, E_0, 16'd7);
      nx(); rst_in = 1'b0; run_in = 1'b0; ex("to_cleared", 3'd0, E_0, 16'd0);
      nx(); ex("to_idle", 3'd0, E_0, 16'd0);

      repeat (2) @(posedge clk_in);
      n_checks++;
      if (q.size() != 0) begin
         n_errors++;
         $display("FAIL drain: got %0d pending, want 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
